// File: rtl/spi_pkg.sv
// Shared SPI slave types and command encodings, also used by the RAM and the wrapper.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // A frame is two command bits followed by the payload.
  function automatic int frame_w(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Serial-in/parallel-out frame assembler with a bit counter; done stays set until cleared.
module spi_shift_reg #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] frame,
  output logic         last,
  output logic         done
);
  localparam int CW = $clog2(W);

  logic [W-2:0]  sr;
  logic [CW-1:0] cnt;

  // frame includes the bit being sampled this cycle, so the caller can latch it on the last edge
  assign frame = {sr, din};
  assign last  = en && !done && (cnt == CW'(W-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (en && !done) begin
      sr <= frame[W-2:0];
      if (last) done <= 1'b1;
      else      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end: assembles MOSI frames into RAM commands and serialises read data onto MISO.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);
  localparam int FRAME_W = frame_w(DATA_W);
  localparam int TCW     = $clog2(DATA_W + 1);

  spi_state_e         state;
  logic               rd_addr_seen;
  logic               tx_busy, tx_done;
  logic [DATA_W-1:0]  tx_sh;
  logic [TCW-1:0]     tx_cnt;
  logic               sr_clr, sr_en, frame_last, frame_done;
  logic [FRAME_W-1:0] frame;

  assign sr_clr = SS_n || (state == IDLE);
  assign sr_en  = !SS_n && (state != IDLE);

  spi_shift_reg #(.W(FRAME_W)) u_rx_sr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sr_clr),
    .en    (sr_en),
    .din   (MOSI),
    .frame (frame),
    .last  (frame_last),
    .done  (frame_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      MISO         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_seen <= 1'b0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      tx_sh        <= '0;
      tx_cnt       <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n) begin
        // abort: drop the partial frame/serialisation but keep rd_addr_seen
        state   <= IDLE;
        MISO    <= 1'b0;
        tx_busy <= 1'b0;
        tx_done <= 1'b0;
        tx_cnt  <= '0;
      end else begin
        case (state)
          IDLE:    state <= CHK_CMD;
          CHK_CMD: state <= !MOSI ? WRITE : (rd_addr_seen ? READ_DATA : READ_ADD);
          WRITE, READ_ADD, READ_DATA: begin
            if (frame_last) begin
              rx_data  <= frame;
              rx_valid <= 1'b1;
              if (state == READ_ADD) rd_addr_seen <= 1'b1;
            end
            if (state == READ_DATA) begin
              if (tx_busy) begin
                if (tx_cnt == TCW'(DATA_W)) begin
                  MISO    <= 1'b0;
                  tx_busy <= 1'b0;
                  tx_done <= 1'b1;
                end else begin
                  MISO   <= tx_sh[DATA_W-1];
                  tx_sh  <= {tx_sh[DATA_W-2:0], 1'b0};
                  tx_cnt <= tx_cnt + 1'b1;
                  if (tx_cnt == TCW'(DATA_W-1)) rd_addr_seen <= 1'b0;
                end
              end else if (frame_done && !tx_done && tx_valid) begin
                // MSB goes straight out; the rest is shifted from tx_sh
                MISO    <= tx_data[DATA_W-1];
                tx_sh   <= {tx_data[DATA_W-2:0], 1'b0};
                tx_cnt  <= TCW'(1);
                tx_busy <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed vector table, reset corner cases, then random transactions.
module tb_spi_slave;
  localparam int DATA_W  = 8;
  localparam int FRAME_W = DATA_W + 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               SS_n = 1'b1;
  logic               MOSI = 1'b0;
  logic               MISO;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data = '0;
  logic               tx_valid = 1'b0;

  int checks = 0;
  int errors = 0;
  bit seen;

  typedef struct {
    logic [FRAME_W-1:0] frame;
    int                 len;
    logic [DATA_W-1:0]  rdata;
    bit                 pulse;
    int                 nbits;
  } vec_t;

  vec_t tbl[12];

  spi_slave #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      SS_n     = 1'b1;
      MOSI     = 1'($urandom);
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = DATA_W'($urandom);
      @(posedge clk); #1;
      chk("idle_rx_valid", 32'(rx_valid), 32'(0));
      chk("idle_miso", 32'(MISO), 32'(0));
    end
  endtask

  // len = edges with SS_n low (edge 0 is the IDLE edge, edges 1..FRAME_W carry frame bits);
  // SS_n goes high for edge len. The RAM answers a complete 11-frame with tx_valid for edge FRAME_W+2.
  task automatic run_txn(input logic [FRAME_W-1:0] frame, input int len, input logic [DATA_W-1:0] rdata,
                         input bit exp_pulse, input int exp_nbits, input int rst_k);
    bit   ram_rd;
    logic mi;
    ram_rd = (len >= FRAME_W + 1) && (frame[FRAME_W-1 -: 2] == 2'b11);
    for (int k = 0; k <= len; k++) begin
      @(negedge clk);
      SS_n     = (k == len);
      MOSI     = (k >= 1 && k <= FRAME_W) ? frame[FRAME_W-k] : 1'($urandom);
      tx_valid = (k == FRAME_W + 2) ? ram_rd :
                 (k == FRAME_W + 1) ? 1'b0 : ($urandom_range(0, 3) == 0);
      tx_data  = (k == FRAME_W + 2) ? rdata : DATA_W'($urandom);
      @(posedge clk); #1;
      chk("rx_valid", 32'(rx_valid), 32'(exp_pulse && k == FRAME_W));
      if (exp_pulse && k == FRAME_W) chk("rx_data", 32'(rx_data), 32'(frame));
      mi = (k >= FRAME_W + 2 && k < FRAME_W + 2 + exp_nbits) ? rdata[DATA_W-1-(k-FRAME_W-2)] : 1'b0;
      chk("miso", 32'(MISO), 32'(mi));
      if (k == rst_k) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst_miso", 32'(MISO), 32'(0));
        chk("async_rst_rx_valid", 32'(rx_valid), 32'(0));
        chk("async_rst_rx_data", 32'(rx_data), 32'(0));
        @(negedge clk);
        SS_n     = 1'b1;
        tx_valid = 1'b0;
        rst_n    = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [FRAME_W-1:0] f;
    logic [DATA_W-1:0]  rd;
    int                 len, nb;
    bit                 pulse;

    // len 6 = abort after 5 bits; len 10 = abort on the last bit; 0x3AA with no prior read addr
    // goes to READ_ADD and its RAM tx_valid must be ignored; len 16 = abort after 4 MISO bits
    tbl[0]  = '{10'h0A5, 12, 8'h00, 1'b1, 0};
    tbl[1]  = '{10'h13C, 12, 8'h00, 1'b1, 0};
    tbl[2]  = '{10'h207, 12, 8'h00, 1'b1, 0};
    tbl[3]  = '{10'h3F0, 22, 8'hC3, 1'b1, 8};
    tbl[4]  = '{10'h05A,  6, 8'h00, 1'b0, 0};
    tbl[5]  = '{10'h05A, 12, 8'h00, 1'b1, 0};
    tbl[6]  = '{10'h1FF, 10, 8'h00, 1'b0, 0};
    tbl[7]  = '{10'h3AA, 13, 8'h5A, 1'b1, 0};
    tbl[8]  = '{10'h355, 16, 8'hA6, 1'b1, 4};
    tbl[9]  = '{10'h300, 21, 8'h96, 1'b1, 8};
    tbl[10] = '{10'h2FF, 14, 8'h81, 1'b1, 0};
    tbl[11] = '{10'h3C3, 20, 8'h3C, 1'b1, 8};

    #3;
    chk("reset_miso", 32'(MISO), 32'(0));
    chk("reset_rx_valid", 32'(rx_valid), 32'(0));
    chk("reset_rx_data", 32'(rx_data), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    foreach (tbl[i]) begin
      run_txn(tbl[i].frame, tbl[i].len, tbl[i].rdata, tbl[i].pulse, tbl[i].nbits, -1);
      idle(1);
    end

    // reset mid-MISO (second bit is 1), then rd_addr_seen must be gone
    run_txn(10'h201, 12, 8'h00, 1'b1, 0, -1);
    run_txn(10'h3FF, 22, 8'hC3, 1'b1, 8, FRAME_W + 3);
    idle(1);
    run_txn(10'h3FF, 22, 8'hC3, 1'b1, 0, -1);
    // reset while rx_valid is high
    run_txn(10'h3FF, 22, 8'h5A, 1'b1, 8, FRAME_W);
    idle(1);
    seen = 1'b0;

    for (int t = 0; t < 80; t++) begin
      f  = FRAME_W'($urandom);
      rd = DATA_W'($urandom);
      if (f[FRAME_W-1] && seen) f[FRAME_W-2] = 1'b1;
      len   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 21) : $urandom_range(11, 24);
      pulse = (len >= FRAME_W + 1);
      nb    = 0;
      if (pulse && f[FRAME_W-1]) begin
        if (!seen) seen = 1'b1;
        else begin
          nb = len - (FRAME_W + 2);
          if (nb < 0) nb = 0;
          if (nb > DATA_W) nb = DATA_W;
          if (len >= FRAME_W + 2 + DATA_W) seen = 1'b0;
        end
      end
      run_txn(f, len, rd, pulse, nb, -1);
      idle($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
